// File: rtl/hist_bin_streamer.sv
// Histogram bin streamer: captures a packed per-cell orientation histogram and
// streams its bins one per cycle over valid/ready, with a one-deep shadow buffer
// so consecutive cells stream back to back. Also reports the L1 sum of each
// fully streamed histogram.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no histogram active, bin_valid low, waiting for a load
// STREAM | active buffer presented bin by bin; shadow may hold the next

module hist_bin_streamer #(
    parameter int NUM_BINS = 9,
    parameter int BIN_W    = 14,
    parameter int IDX_W    = 4,
    parameter int SUM_W    = 18
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_BINS*BIN_W-1:0] hist_in,
    input  logic                      hist_load,
    output logic                      load_ready,
    output logic                      load_drop,
    output logic [BIN_W-1:0]          bin_data,
    output logic [IDX_W-1:0]          bin_idx,
    output logic                      bin_valid,
    input  logic                      bin_ready,
    output logic                      bin_last,
    output logic [SUM_W-1:0]          sum_out,
    output logic                      sum_valid
);

    localparam int                HIST_W   = NUM_BINS * BIN_W;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_BINS - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [HIST_W-1:0]  active_buf;
    logic [HIST_W-1:0]  shadow_buf;
    logic               shadow_full;
    logic [IDX_W-1:0]   idx;
    logic [SUM_W-1:0]   acc;
    logic [SUM_W-1:0]   bin_ext;

    logic               streaming;
    logic               xfer;
    logic               last_xfer;
    logic               load_acc;
    logic               take_load_active;
    logic               take_load_shadow;
    logic               promote_shadow;
    logic               advance_idx;

    // Handshake qualifiers derived straight from registered state
    assign streaming  = (state == STREAM);
    assign load_ready = ~shadow_full;
    assign load_acc   = hist_load & load_ready;
    assign xfer       = streaming & bin_ready;
    assign last_xfer  = xfer & (idx == LAST_IDX);

    assign bin_valid  = streaming;
    assign bin_idx    = idx;
    assign bin_data   = active_buf[int'(idx) * BIN_W +: BIN_W];
    assign bin_last   = streaming & (idx == LAST_IDX);
    assign bin_ext    = {{(SUM_W - BIN_W){1'b0}}, bin_data};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and buffer-steering decisions
    always_comb begin
        state_nxt        = state;
        take_load_active = 1'b0;
        take_load_shadow = 1'b0;
        promote_shadow   = 1'b0;
        advance_idx      = 1'b0;
        case (state)
            IDLE: begin
                if (load_acc) begin
                    take_load_active = 1'b1;
                    state_nxt        = STREAM;
                end
            end
            STREAM: begin
                if (last_xfer) begin
                    // a full shadow wins; load_ready is low so a concurrent load drops
                    if (shadow_full) begin
                        promote_shadow = 1'b1;
                    end else if (hist_load) begin
                        take_load_active = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    advance_idx      = xfer;
                    take_load_shadow = load_acc;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Active buffer and bin index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_buf <= '0;
            idx        <= '0;
        end else if (take_load_active) begin
            active_buf <= hist_in;
            idx        <= '0;
        end else if (promote_shadow) begin
            active_buf <= shadow_buf;
            idx        <= '0;
        end else if (advance_idx) begin
            idx <= idx + IDX_W'(1);
        end
    end

    // Shadow buffer holding the next histogram while the active one streams
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_buf  <= '0;
            shadow_full <= 1'b0;
        end else if (take_load_shadow) begin
            shadow_buf  <= hist_in;
            shadow_full <= 1'b1;
        end else if (promote_shadow) begin
            shadow_full <= 1'b0;
        end
    end

    // L1 accumulator; restarts whenever a histogram completes or a new one lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (last_xfer || take_load_active) begin
            acc <= '0;
        end else if (xfer) begin
            acc <= acc + bin_ext;
        end
    end

    // Sum result and status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_out   <= '0;
            sum_valid <= 1'b0;
            load_drop <= 1'b0;
        end else begin
            sum_valid <= last_xfer;
            load_drop <= hist_load & ~load_ready;
            if (last_xfer) begin
                sum_out <= acc + bin_ext;
            end
        end
    end

endmodule

// File: tb/tb_hist_bin_streamer.sv
// Directed bench for hist_bin_streamer: streams hand-built histograms and
// compares transfers, sums, drops and reset behaviour against fixed values.

module tb_hist_bin_streamer;

    localparam int NB = 9;
    localparam int BW = 14;
    localparam int IW = 4;
    localparam int SW = 18;
    localparam int HW = NB * BW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [HW-1:0] hist_in = '0;
    logic          hist_load = 1'b0;
    logic          load_ready;
    logic          load_drop;
    logic [BW-1:0] bin_data;
    logic [IW-1:0] bin_idx;
    logic          bin_valid;
    logic          bin_ready = 1'b1;
    logic          bin_last;
    logic [SW-1:0] sum_out;
    logic          sum_valid;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    int n_drop = 0;

    int xf_data[$];
    int xf_idx[$];
    int xf_last[$];
    int xf_cyc[$];
    int sm_val[$];
    int sm_cyc[$];
    int exp_data[$];
    int exp_sum[$];

    logic          prev_stall = 1'b0;
    logic [BW-1:0] prv_data;
    logic [IW-1:0] prv_idx;

    hist_bin_streamer #(
        .NUM_BINS(NB),
        .BIN_W   (BW),
        .IDX_W   (IW),
        .SUM_W   (SW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hist_in   (hist_in),
        .hist_load (hist_load),
        .load_ready(load_ready),
        .load_drop (load_drop),
        .bin_data  (bin_data),
        .bin_idx   (bin_idx),
        .bin_valid (bin_valid),
        .bin_ready (bin_ready),
        .bin_last  (bin_last),
        .sum_out   (sum_out),
        .sum_valid (sum_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Observe outputs mid-cycle: log transfers, sums and drops, verify stall hold
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", bin_valid, 1);
                chk("hold_data", bin_data, prv_data);
                chk("hold_idx", bin_idx, prv_idx);
            end
            prev_stall = bin_valid & ~bin_ready;
            prv_data   = bin_data;
            prv_idx    = bin_idx;
            if (bin_valid && bin_ready) begin
                xf_data.push_back(int'(bin_data));
                xf_idx.push_back(int'(bin_idx));
                xf_last.push_back(int'(bin_last));
                xf_cyc.push_back(cyc);
            end
            if (sum_valid) begin
                sm_val.push_back(int'(sum_out));
                sm_cyc.push_back(cyc);
            end
            if (load_drop) n_drop++;
        end
    end

    function automatic logic [HW-1:0] mk_hist(input int base, input int step);
        logic [HW-1:0] h;
        h = '0;
        for (int k = 0; k < NB; k++) h[k*BW +: BW] = BW'(base + step * k);
        return h;
    endfunction

    task automatic add_exp(input int base, input int step);
        int s;
        s = 0;
        for (int k = 0; k < NB; k++) begin
            exp_data.push_back(base + step * k);
            s += base + step * k;
        end
        exp_sum.push_back(s);
    endtask

    task automatic clear_logs();
        xf_data.delete(); xf_idx.delete(); xf_last.delete(); xf_cyc.delete();
        sm_val.delete(); sm_cyc.delete(); exp_data.delete(); exp_sum.delete();
        n_drop = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [HW-1:0] h);
        hist_in   = h;
        hist_load = 1'b1;
        tick();
        hist_load = 1'b0;
    endtask

    task automatic run_until_idle();
        for (int g = 0; g < 80 && bin_valid; g++) tick();
        chk("idle_reached", bin_valid, 0);
        tick();
        tick();
    endtask

    task automatic wait_idx(input int target);
        for (int g = 0; g < 40 && !(bin_valid && int'(bin_idx) == target); g++) tick();
        chk("reach_idx", bin_idx, target);
    endtask

    task automatic check_log(input bit gapless);
        chk("xfer_count", xf_data.size(), exp_data.size());
        for (int i = 0; i < exp_data.size() && i < xf_data.size(); i++) begin
            chk("xfer_data", xf_data[i], exp_data[i]);
            chk("xfer_idx", xf_idx[i], i % NB);
            chk("xfer_last", xf_last[i], ((i % NB) == NB - 1) ? 1 : 0);
            if (gapless && i > 0) chk("no_bubble", xf_cyc[i] - xf_cyc[i-1], 1);
        end
        chk("sum_count", sm_val.size(), exp_sum.size());
        for (int j = 0; j < exp_sum.size() && j < sm_val.size(); j++) begin
            chk("sum_value", sm_val[j], exp_sum[j]);
            if (j * NB + NB - 1 < xf_cyc.size())
                chk("sum_timing", sm_cyc[j] - xf_cyc[j*NB + NB - 1], 1);
        end
        chk("load_ready_end", load_ready, 1);
    endtask

    initial begin
        // reset values
        #2;
        chk("rst_load_ready", load_ready, 1);
        chk("rst_bin_valid", bin_valid, 0);
        chk("rst_bin_idx", bin_idx, 0);
        chk("rst_bin_data", bin_data, 0);
        chk("rst_bin_last", bin_last, 0);
        chk("rst_sum_out", sum_out, 0);
        chk("rst_sum_valid", sum_valid, 0);
        chk("rst_load_drop", load_drop, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // single histogram, consumer always ready
        clear_logs();
        add_exp(1, 1);
        load(mk_hist(1, 1));
        chk("lat1_valid", bin_valid, 1);
        chk("lat1_idx", bin_idx, 0);
        chk("lat1_data", bin_data, 1);
        run_until_idle();
        check_log(1'b1);
        chk("t1_drops", n_drop, 0);
        chk("t1_sum_hold", sum_out, 45);

        // backpressure pattern 1,0,0,1
        clear_logs();
        add_exp(1, 1);
        load(mk_hist(1, 1));
        for (int t = 0; t < 80 && bin_valid; t++) begin
            bin_ready = ((t % 4) == 0 || (t % 4) == 3);
            tick();
        end
        bin_ready = 1'b1;
        run_until_idle();
        check_log(1'b0);

        // back-to-back A then B, with a third load C dropped
        clear_logs();
        add_exp(16383, 0);
        add_exp(1, 0);
        load(mk_hist(16383, 0));
        tick();
        tick();
        chk("b2b_idx_before_b", bin_idx, 2);
        load(mk_hist(1, 0));
        chk("b2b_load_ready_low", load_ready, 0);
        load(mk_hist(341, 0));
        chk("drop_pulse", load_drop, 1);
        tick();
        chk("drop_pulse_end", load_drop, 0);
        run_until_idle();
        check_log(1'b1);
        chk("drop_count", n_drop, 1);

        // load arriving with A's last transfer, shadow empty
        clear_logs();
        add_exp(16383, 0);
        add_exp(9, -1);
        load(mk_hist(16383, 0));
        wait_idx(8);
        load(mk_hist(9, -1));
        chk("direct_idx", bin_idx, 0);
        chk("direct_data", bin_data, 9);
        chk("direct_valid", bin_valid, 1);
        run_until_idle();
        check_log(1'b1);
        chk("t4_drops", n_drop, 0);

        // reset in the middle of a stream
        clear_logs();
        load(mk_hist(1, 1));
        wait_idx(4);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", bin_valid, 0);
        chk("mid_rst_load_ready", load_ready, 1);
        chk("mid_rst_idx", bin_idx, 0);
        chk("mid_rst_data", bin_data, 0);
        chk("mid_rst_sum_out", sum_out, 0);
        chk("mid_rst_last", bin_last, 0);
        tick();
        tick();
        chk("mid_rst_no_sum", sm_val.size(), 0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_no_sum", sm_val.size(), 0);
        chk("post_rst_idle", bin_valid, 0);
        clear_logs();
        add_exp(9, -1);
        load(mk_hist(9, -1));
        chk("post_rst_idx", bin_idx, 0);
        run_until_idle();
        check_log(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
